// File: rtl/cellrv32_npu_instr_buffer.sv
// Assembles multi-beat NPU instructions (LSB beat first) and queues the decoded fields in a FWFT FIFO.
// Optional feature macro: CELLRV32_NPU_INSTR_ZERO_LEN_DROP_EN discards instructions whose calc length is zero.
module cellrv32_npu_instr_buffer #(
  parameter int BUS_WIDTH  = 32,
  parameter int BUF_ADDR_W = 24,
  parameter int ACC_ADDR_W = 16,
  parameter int LEN_W      = 32,
  parameter int OPC_W      = 8,
  parameter int DEPTH      = 4,
  parameter logic [OPC_W-1:0] WEIGHT_OPC = OPC_W'(8'h08)
) (
  input  logic                             clk_i,
  input  logic                             rstn_i,
  input  logic                             flush_i,
  input  logic [BUS_WIDTH-1:0]             in_data_i,
  input  logic                             in_valid_i,
  output logic                             in_ready_o,
  output logic [OPC_W-1:0]                 out_opcode_o,
  output logic [LEN_W-1:0]                 out_len_o,
  output logic [ACC_ADDR_W-1:0]            out_acc_addr_o,
  output logic [BUF_ADDR_W-1:0]            out_buf_addr_o,
  output logic [BUF_ADDR_W+ACC_ADDR_W-1:0] out_wei_addr_o,
  output logic                             out_is_weight_o,
  output logic                             out_valid_o,
  input  logic                             out_ready_i,
  output logic [$clog2(DEPTH):0]           count_o,
  output logic                             drop_o
);

  localparam int IW        = OPC_W + LEN_W + ACC_ADDR_W + BUF_ADDR_W;
  localparam int BEATS     = (IW + BUS_WIDTH - 1) / BUS_WIDTH;
  localparam int BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PTR_W     = $clog2(DEPTH);
  localparam int CNT_W     = PTR_W + 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [IW-1:0]     asm_q, asm_d;
  logic [IW-1:0]     instr;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [IW-1:0]     mem_q [DEPTH];
  logic [IW-1:0]     head;

  logic full, empty, beat_acc, last_beat, push, pop, keep_instr;

  // Overlay the incoming beat onto the partial word; bits past IW in the last beat fall away.
  always_comb begin
    instr = asm_q;
    for (int b = 0; b < IW; b++) begin
      if (int'(beat_cnt_q) == b / BUS_WIDTH) begin
        instr[b] = in_data_i[b % BUS_WIDTH];
      end
    end
  end

  always_comb begin
    full       = (count_q == CNT_W'(DEPTH));
    empty      = (count_q == '0);
    in_ready_o = !full;
    beat_acc   = in_valid_i && !full && !flush_i;
    last_beat  = (beat_cnt_q == LAST_BEAT);
    pop        = !empty && out_ready_i && !flush_i;
`ifdef CELLRV32_NPU_INSTR_ZERO_LEN_DROP_EN
    keep_instr = |instr[OPC_W +: LEN_W];
`else
    keep_instr = 1'b1;
`endif
    push       = beat_acc && last_beat && keep_instr;
  end

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    asm_d      = asm_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (flush_i) begin
      beat_cnt_d = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (beat_acc) begin
        asm_d      = instr;
        beat_cnt_d = last_beat ? '0 : beat_cnt_q + BEAT_W'(1);
      end
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      beat_cnt_q <= '0;
      asm_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      asm_q      <= asm_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset: entries are only observed through count_q.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= instr;
  end

`ifdef CELLRV32_NPU_INSTR_ZERO_LEN_DROP_EN
  logic drop_q, drop_d;

  always_comb begin
    drop_d = beat_acc && last_beat && !keep_instr;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) drop_q <= 1'b0;
    else         drop_q <= drop_d;
  end

  assign drop_o = drop_q;
`else
  assign drop_o = 1'b0;
`endif

  assign head            = mem_q[rd_ptr_q];
  assign out_opcode_o    = head[0 +: OPC_W];
  assign out_len_o       = head[OPC_W +: LEN_W];
  assign out_acc_addr_o  = head[OPC_W + LEN_W +: ACC_ADDR_W];
  assign out_buf_addr_o  = head[OPC_W + LEN_W + ACC_ADDR_W +: BUF_ADDR_W];
  assign out_wei_addr_o  = head[IW-1 -: BUF_ADDR_W + ACC_ADDR_W];
  assign out_is_weight_o = (head[0 +: OPC_W] == WEIGHT_OPC);
  assign out_valid_o     = !empty;
  assign count_o         = count_q;

endmodule

// File: doc/cellrv32_npu_instr_buffer.md
CELLRV32_NPU_INSTR_BUFFER -- requirements
Module: cellrv32_npu_instr_buffer

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 32, meaning input beat width in bits (8..64).
REQ-002 SHALL have parameter BUF_ADDR_W, default 24, meaning buffer address field width.
REQ-003 SHALL have parameter ACC_ADDR_W, default 16, meaning accumulator address field width.
REQ-004 SHALL have parameter LEN_W, default 32, meaning calc-length field width.
REQ-005 SHALL have parameter OPC_W, default 8, meaning opcode field width.
REQ-006 SHALL have parameter DEPTH, default 4, meaning decoded-instruction FIFO entries (power of 2, >=2).
REQ-007 SHALL have parameter WEIGHT_OPC, default 8'h08, meaning the opcode value classified as a weight-load instruction.
REQ-008 SHALL have ports, one clock, reset asynchronous active-low:
- clk_i  in  1  clock
- rstn_i  in  1  async active-low reset
- flush_i  in  1  synchronous clear of FIFO and partial assembly
- in_data_i  in  BUS_WIDTH  instruction beat, least-significant beat first
- in_valid_i  in  1  beat valid
- in_ready_o  out  1  beat accepted when valid and ready
- out_opcode_o  out  OPC_W  head opcode
- out_len_o  out  LEN_W  head calc length
- out_acc_addr_o  out  ACC_ADDR_W  head accumulator address
- out_buf_addr_o  out  BUF_ADDR_W  head buffer address
- out_wei_addr_o  out  BUF_ADDR_W+ACC_ADDR_W  {buf_addr, acc_addr}
- out_is_weight_o  out  1  head opcode equals WEIGHT_OPC
- out_valid_o  out  1  FIFO non-empty
- out_ready_i  in  1  consumer pops head
- count_o  out  clog2(DEPTH)+1  FIFO occupancy
- drop_o  out  1  one-cycle pulse, zero-length instruction discarded

Function
REQ-009 SHALL define IW = OPC_W+LEN_W+ACC_ADDR_W+BUF_ADDR_W and BEATS = ceil(IW/BUS_WIDTH).
REQ-010 SHALL pack the instruction LSB-first as opcode [OPC_W-1:0], then calc_len, then acc_addr, then buf_addr in the top bits.
REQ-011 SHALL place beat k at bits [k*BUS_WIDTH +: BUS_WIDTH] and ignore any bits above IW-1 in the final beat.
REQ-012 SHALL count accepted beats with a beat counter 0..BEATS-1 that wraps to 0 after the final beat.
REQ-013 SHALL drive in_ready_o = !full, combinationally, for every beat.
REQ-014 SHALL write the decoded instruction into the FIFO on the edge accepting the final beat, so out_valid_o rises in the next cycle (1-cycle latency).
REQ-015 SHALL make the FIFO first-word-fall-through: out_* reflect the head entry whenever out_valid_o=1.
REQ-016 SHALL pop the head on an edge where out_valid_o && out_ready_i.
REQ-017 SHALL perform push and pop in the same cycle when not full and not empty; count_o is then unchanged.
REQ-018 SHALL wrap read and write pointers modulo DEPTH.
REQ-019 SHALL, while full, hold in_ready_o=0 and freeze partial assembly state.
REQ-020 SHALL, on flush_i=1, empty the FIFO, zero the beat counter, and ignore any same-cycle beat, push or pop; flush wins over all.
REQ-021 SHALL keep out_* values don't-care when out_valid_o=0; the bench checks them only when valid.

Reset
REQ-022 SHALL, on rstn_i low, asynchronously clear the pointers, count_o, beat counter, out_valid_o and drop_o to 0, with in_ready_o=1 after release.
REQ-023 SHALL, on reset asserted mid-assembly, discard the partial instruction; the next accepted beat is beat 0.

Configuration
REQ-024 SHALL implement macro CELLRV32_NPU_INSTR_ZERO_LEN_DROP_EN as follows:
- Defined: an assembled instruction with calc_len==0 is not written to the FIFO, and drop_o pulses high for one cycle after the final beat.
- Undefined: all instructions are written, and drop_o is tied 0.

Verification
REQ-025 SHALL cover these scenarios with default parameters:
- Single instruction: beats 0x00001008, 0x56ABCD00, 0x00001234 -> next cycle out_valid_o=1, opcode=0x08, len=0x10, acc=0xABCD, buf=0x123456, wei_addr=0x123456ABCD, is_weight=1.
- Fill: 4 instructions with out_ready_i=0 -> count_o=4, in_ready_o=0; then one pop -> in_ready_o=1 next cycle, FIFO order preserved.
- Simultaneous: count_o=2, final beat pushed and head popped on the same edge -> count_o stays 2.
- Flush: after 2 beats of an instruction plus 1 queued entry, flush_i=1 -> count_o=0, out_valid_o=0; the next 3 beats form a fresh instruction.
- Reset mid-assembly: rstn_i low after beat 1 -> all outputs at reset values; the following beat is treated as beat 0.
- Zero length with macro defined: instruction with len=0 -> drop_o=1 for one cycle, count_o unchanged; with macro undefined -> count_o increments and drop_o stays 0.
